// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-memory request per instruction, aligns and
// extends load data, registers the writeback bundle and stalls upstream while busy.
module memory_stage #(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [4:0]      ex_wb_addr,
  input  logic            ex_rf_wen,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_mem_val,
  input  logic            ex_mem_fcn,
  input  logic [2:0]      ex_mem_typ,
  input  logic [1:0]      ex_wb_sel,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [3:0]      dmem_req_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_data,
  output logic            mem_stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic [4:0]      wb_addr,
  output logic            wb_wen,
  output logic [XLEN-1:0] wb_data,
  output logic [1:0]      wb_exc
);

  // state     | meaning
  // IDLE      | sampling execute bundle; memory ops issue their request this cycle
  // WAIT_REQ  | request presented, waiting for dmem_req_ready
  // WAIT_RESP | request accepted, waiting for response or timeout
  typedef enum logic [1:0] {IDLE, WAIT_REQ, WAIT_RESP} state_e;

  localparam logic [7:0] TO_LOAD = 8'(RESP_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, alu_q, alu_d, rs2_q, rs2_d;
  logic [4:0]      waddr_q, waddr_d;
  logic            rfwen_q, rfwen_d, fcn_q, fcn_d;
  logic [2:0]      typ_q, typ_d;
  logic [1:0]      sel_q, sel_d;
  logic            wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d;
  logic [XLEN-1:0] wb_pc_q, wb_pc_d, wb_data_q, wb_data_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [1:0]      wb_exc_q, wb_exc_d;

  logic            bad_ex, accept;
  logic [XLEN-1:0] r_addr, r_rs2, ld_data;
  logic            r_fcn;
  logic [2:0]      r_typ;
  logic [XLEN-1:0] fmt_wdata;
  logic [3:0]      fmt_wstrb;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;

  function automatic logic bad_access(input logic [2:0] typ, input logic [1:0] off);
    case (typ)
      3'd0, 3'd4: bad_access = 1'b0;
      3'd1, 3'd5: bad_access = off[0];
      3'd2:       bad_access = (off != 2'b00);
      default:    bad_access = 1'b1;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sel_data(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                               input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ld);
    case (sel)
      2'd0:    sel_data = alu;
      2'd1:    sel_data = ld;
      2'd2:    sel_data = pc + XLEN'(4);
      default: sel_data = '0;
    endcase
  endfunction

  assign bad_ex = bad_access(ex_mem_typ, ex_alu_out[1:0]);
  // Gated by rst_n so the combinational request path is quiet while in reset
  assign accept = rst_n && (state_q == IDLE) && ex_valid && ex_mem_val && !bad_ex;

  assign r_addr = (state_q == IDLE) ? ex_alu_out  : alu_q;
  assign r_rs2  = (state_q == IDLE) ? ex_rs2_data : rs2_q;
  assign r_fcn  = (state_q == IDLE) ? ex_mem_fcn  : fcn_q;
  assign r_typ  = (state_q == IDLE) ? ex_mem_typ  : typ_q;

  always_comb begin
    fmt_wdata = '0;
    fmt_wstrb = 4'b0000;
    if (r_fcn) begin
      case (r_typ[1:0])
        2'd0: begin
          fmt_wdata = {4{r_rs2[7:0]}};
          fmt_wstrb = 4'b0001 << r_addr[1:0];
        end
        2'd1: begin
          fmt_wdata = {2{r_rs2[15:0]}};
          fmt_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          fmt_wdata = r_rs2;
          fmt_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign dmem_req_valid = accept || (state_q == WAIT_REQ);
  assign dmem_req_addr  = dmem_req_valid ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign dmem_req_we    = dmem_req_valid && r_fcn;
  assign dmem_req_wdata = dmem_req_valid ? fmt_wdata : '0;
  assign dmem_req_wstrb = dmem_req_valid ? fmt_wstrb : 4'b0000;

  assign ld_b = dmem_resp_data[{alu_q[1:0], 3'b000} +: 8];
  assign ld_h = alu_q[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];

  always_comb begin
    case (typ_q)
      3'd0:    ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'd4:    ld_data = {{(XLEN-8){1'b0}}, ld_b};
      3'd1:    ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'd5:    ld_data = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_data = dmem_resp_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    alu_d      = alu_q;
    rs2_d      = rs2_q;
    waddr_d    = waddr_q;
    rfwen_d    = rfwen_q;
    fcn_d      = fcn_q;
    typ_d      = typ_q;
    sel_d      = sel_q;
    wb_valid_d = 1'b0;
    wb_pc_d    = '0;
    wb_addr_d  = '0;
    wb_wen_d   = 1'b0;
    wb_data_d  = '0;
    wb_exc_d   = 2'd0;
    mem_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mem_stall = 1'b1;
          pc_d      = ex_pc;
          alu_d     = ex_alu_out;
          rs2_d     = ex_rs2_data;
          waddr_d   = ex_wb_addr;
          rfwen_d   = ex_rf_wen;
          fcn_d     = ex_mem_fcn;
          typ_d     = ex_mem_typ;
          sel_d     = ex_wb_sel;
          cnt_d     = TO_LOAD;
          state_d   = dmem_req_ready ? WAIT_RESP : WAIT_REQ;
        end else if (ex_valid) begin
          wb_valid_d = 1'b1;
          wb_pc_d    = ex_pc;
          wb_addr_d  = ex_wb_addr;
          if (ex_mem_val) begin
            wb_exc_d = 2'd1;
          end else begin
            wb_wen_d  = ex_rf_wen && (ex_wb_addr != 5'd0);
            wb_data_d = sel_data(ex_wb_sel, ex_alu_out, ex_pc, '0);
          end
        end
      end
      WAIT_REQ: begin
        mem_stall = 1'b1;
        if (dmem_req_ready) begin
          cnt_d   = TO_LOAD;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (dmem_resp_valid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_pc_d    = pc_q;
          wb_addr_d  = waddr_q;
          wb_wen_d   = rfwen_q && !fcn_q && (waddr_q != 5'd0);
          wb_data_d  = sel_data(sel_q, alu_q, pc_q, ld_data);
        end else if (cnt_q == 8'd0) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_pc_d    = pc_q;
          wb_addr_d  = waddr_q;
          wb_exc_d   = 2'd2;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      alu_q      <= '0;
      rs2_q      <= '0;
      waddr_q    <= '0;
      rfwen_q    <= 1'b0;
      fcn_q      <= 1'b0;
      typ_q      <= '0;
      sel_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_addr_q  <= '0;
      wb_wen_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_exc_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      rs2_q      <= rs2_d;
      waddr_q    <= waddr_d;
      rfwen_q    <= rfwen_d;
      fcn_q      <= fcn_d;
      typ_q      <= typ_d;
      sel_q      <= sel_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_addr_q  <= wb_addr_d;
      wb_wen_q   <= wb_wen_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_pc    = wb_pc_q;
  assign wb_addr  = wb_addr_q;
  assign wb_wen   = wb_wen_q;
  assign wb_data  = wb_data_q;
  assign wb_exc   = wb_exc_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases then randomized instructions checked against
// an arithmetic reference model of request formatting and load extraction.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_rf_wen, ex_mem_val, ex_mem_fcn;
  logic [31:0] ex_pc, ex_alu_out, ex_rs2_data;
  logic [4:0]  ex_wb_addr;
  logic [2:0]  ex_mem_typ;
  logic [1:0]  ex_wb_sel;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_resp_valid;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_resp_data;
  logic [3:0]  dmem_req_wstrb;
  logic        mem_stall, wb_valid, wb_wen;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_addr;
  logic [1:0]  wb_exc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_wb_addr(ex_wb_addr), .ex_rf_wen(ex_rf_wen),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data), .ex_mem_val(ex_mem_val),
    .ex_mem_fcn(ex_mem_fcn), .ex_mem_typ(ex_mem_typ), .ex_wb_sel(ex_wb_sel),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_addr(wb_addr),
    .wb_wen(wb_wen), .wb_data(wb_data), .wb_exc(wb_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misal_m(input logic [2:0] typ, input logic [31:0] a);
    int sz;
    case (typ)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    return 1'b1;
    endcase
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ld_m(input logic [2:0] typ, input logic [31:0] a, input logic [31:0] w);
    int off = int'(a % 4);
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (typ)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wd_m(input logic [2:0] typ, input logic [31:0] rs2);
    case (typ)
      3'd0, 3'd4: return (rs2 & 32'hFF) * 32'h01010101;
      3'd1, 3'd5: return (rs2 & 32'hFFFF) * 32'h00010001;
      default:    return rs2;
    endcase
  endfunction

  function automatic logic [3:0] st_m(input logic [2:0] typ, input logic [31:0] a);
    int off = int'(a % 4);
    case (typ)
      3'd0, 3'd4: return 4'(1 << off);
      3'd1, 3'd5: return (off >= 2) ? 4'd12 : 4'd3;
      default:    return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] sel_m(input logic [1:0] sel, input logic [31:0] alu,
                                        input logic [31:0] pc, input logic [31:0] ld);
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      default: return pc + 32'd4;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, dmem_req_valid, 0);
    chk({tag, "_req_addr"}, dmem_req_addr, 0);
    chk({tag, "_req_we"}, dmem_req_we, 0);
    chk({tag, "_req_wdata"}, dmem_req_wdata, 0);
    chk({tag, "_req_wstrb"}, dmem_req_wstrb, 0);
    chk({tag, "_stall"}, mem_stall, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_pc"}, wb_pc, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_wen"}, wb_wen, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_exc"}, wb_exc, 0);
  endtask

  // Called at posedge+1 with the stage idle; drives one instruction through to writeback.
  task automatic run_op(input string tag, input logic v, input logic [31:0] pc, input logic [4:0] wa,
                        input logic rfw, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic mv, input logic fcn, input logic [2:0] typ, input logic [1:0] sel,
                        input int rdly, input int sdly, input logic [31:0] rdata, input bit junk);
    bit bad = v && mv && misal_m(typ, alu);
    bit ismem = v && mv && !bad;
    ex_valid = v; ex_pc = pc; ex_wb_addr = wa; ex_rf_wen = rfw; ex_alu_out = alu;
    ex_rs2_data = rs2; ex_mem_val = mv; ex_mem_fcn = fcn; ex_mem_typ = typ; ex_wb_sel = sel;
    #1;
    if (!ismem) begin
      chk({tag, "_noreq"}, dmem_req_valid, 0);
      chk({tag, "_nostall"}, mem_stall, 0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      chk({tag, "_wb_valid"}, wb_valid, v);
      if (bad) begin
        chk({tag, "_wb_exc"}, wb_exc, 1);
        chk({tag, "_wb_wen"}, wb_wen, 0);
        chk({tag, "_wb_pc"}, wb_pc, pc);
      end else if (v) begin
        chk({tag, "_wb_exc"}, wb_exc, 0);
        chk({tag, "_wb_wen"}, wb_wen, rfw && wa != 0);
        chk({tag, "_wb_data"}, wb_data, sel_m(sel, alu, pc, 32'd0));
        chk({tag, "_wb_pc"}, wb_pc, pc);
        chk({tag, "_wb_addr"}, wb_addr, wa);
      end else begin
        chk({tag, "_wb_wen"}, wb_wen, 0);
      end
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        dmem_req_ready = (i == rdly);
        dmem_resp_valid = junk && (i == 0);
        dmem_resp_data = 32'hA5A5A5A5;
        #1;
        chk({tag, "_req_valid"}, dmem_req_valid, 1);
        chk({tag, "_req_addr"}, dmem_req_addr, alu & 32'hFFFFFFFC);
        chk({tag, "_req_we"}, dmem_req_we, fcn);
        chk({tag, "_req_wdata"}, dmem_req_wdata, fcn ? wd_m(typ, rs2) : 32'd0);
        chk({tag, "_req_wstrb"}, dmem_req_wstrb, fcn ? st_m(typ, alu) : 4'd0);
        chk({tag, "_stall_req"}, mem_stall, 1);
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        ex_alu_out = $urandom; ex_rs2_data = $urandom; ex_pc = $urandom;
        ex_mem_typ = 3'($urandom); ex_wb_sel = 2'($urandom); ex_wb_addr = 5'($urandom);
      end
      dmem_req_ready = 1'b0;
      for (int i = 0; i < sdly; i++) begin
        #1;
        chk({tag, "_stall_resp"}, mem_stall, 1);
        chk({tag, "_wb_quiet"}, wb_valid, 0);
        chk({tag, "_req_done"}, dmem_req_valid, 0);
        @(posedge clk); #1;
      end
      dmem_resp_valid = 1'b1;
      dmem_resp_data = rdata;
      #1;
      chk({tag, "_stall_release"}, mem_stall, 0);
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
      ex_valid = 1'b0;
      chk({tag, "_wb_valid"}, wb_valid, 1);
      chk({tag, "_wb_exc"}, wb_exc, 0);
      chk({tag, "_wb_wen"}, wb_wen, rfw && !fcn && wa != 0);
      chk({tag, "_wb_data"}, wb_data, sel_m(sel, alu, pc, ld_m(typ, alu, rdata)));
      chk({tag, "_wb_pc"}, wb_pc, pc);
      chk({tag, "_wb_addr"}, wb_addr, wa);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ex_valid = 0; ex_pc = 0; ex_wb_addr = 0; ex_rf_wen = 0; ex_alu_out = 0; ex_rs2_data = 0;
    ex_mem_val = 0; ex_mem_fcn = 0; ex_mem_typ = 0; ex_wb_sel = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_data = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("alu", 1, 32'h400, 5, 1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_op("lb", 1, 32'h404, 7, 1, 32'h103, 0, 1, 0, 3'd0, 1, 0, 1, 32'h80FFFFFF, 0);
    run_op("lbu", 1, 32'h408, 7, 1, 32'h103, 0, 1, 0, 3'd4, 1, 0, 1, 32'h80FFFFFF, 0);
    run_op("sh", 1, 32'h40C, 3, 1, 32'h202, 32'hDEADBEEF, 1, 1, 3'd1, 0, 3, 1, 0, 0);
    run_op("lw_mis", 1, 32'h410, 9, 1, 32'h101, 0, 1, 0, 3'd2, 1, 0, 0, 0, 0);
    run_op("illegal_typ", 1, 32'h414, 9, 1, 32'h100, 0, 1, 0, 3'd3, 1, 0, 0, 0, 0);
    run_op("jal", 1, 32'hFFFFFFFC, 1, 1, 32'h0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    run_op("x0", 1, 32'h418, 0, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_op("bubble", 0, 32'h41C, 4, 1, 32'h66, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    run_op("lh_junk", 1, 32'h420, 8, 1, 32'h302, 0, 1, 0, 3'd1, 1, 0, 0, 32'h8001_7FFF, 1);

    // response timeout followed by a stray response
    ex_valid = 1; ex_pc = 32'h500; ex_wb_addr = 6; ex_rf_wen = 1; ex_alu_out = 32'h600;
    ex_mem_val = 1; ex_mem_fcn = 0; ex_mem_typ = 3'd2; ex_wb_sel = 1; dmem_req_ready = 1;
    #1 chk("to_req_valid", dmem_req_valid, 1);
    @(posedge clk); #1;
    dmem_req_ready = 0; ex_valid = 0;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (wb_valid) break;
    end
    chk("to_cycles", n, 255);
    chk("to_exc", wb_exc, 2);
    chk("to_wen", wb_wen, 0);
    chk("to_pc", wb_pc, 32'h500);
    dmem_resp_valid = 1; dmem_resp_data = 32'h1;
    #1 chk("stray_stall", mem_stall, 0);
    @(posedge clk); #1;
    dmem_resp_valid = 0;
    chk("stray_wb_valid", wb_valid, 0);
    chk("stray_req", dmem_req_valid, 0);

    // asynchronous reset while waiting for a response
    ex_valid = 1; ex_alu_out = 32'h700; ex_mem_typ = 3'd2; dmem_req_ready = 1;
    @(posedge clk); #1;
    dmem_req_ready = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    ex_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    dmem_resp_valid = 1; dmem_resp_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_resp_valid = 0;
    chk("late_resp_wb", wb_valid, 0);
    chk("late_resp_stall", mem_stall, 0);

    for (int k = 0; k < 60; k++) begin
      logic mv = ($urandom_range(0, 3) != 0);
      logic [1:0] sel = mv ? 2'($urandom_range(0, 2)) : ($urandom_range(0, 1) ? 2'd2 : 2'd0);
      logic [4:0] wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_op("rand", ($urandom_range(0, 9) != 0), $urandom, wa, 1'($urandom), $urandom, $urandom,
             mv, 1'($urandom), 3'($urandom), sel, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage. Consumes the execute result (ALU output, store data, memory control), issues at most one data-memory request per instruction over a valid/ready handshake, and aligns and extends load data. It registers the writeback bundle for the writeback stage and asserts a stall to pipeline control while a memory access is outstanding.

Parameters:
XLEN, 32, data/address width
RESP_TIMEOUT, 255, cycles in WAIT_RESP before a bus-error fault (8-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute bundle holds a real instruction (not a bubble)
ex_pc  in  XLEN  instruction PC
ex_wb_addr  in  5  destination register
ex_rf_wen  in  1  register-file write enable
ex_alu_out  in  XLEN  ALU result / effective address
ex_rs2_data  in  XLEN  store data
ex_mem_val  in  1  instruction accesses memory
ex_mem_fcn  in  1  0=load, 1=store
ex_mem_typ  in  3  0=B 1=H 2=W 4=BU 5=HU; others illegal
ex_wb_sel  in  2  0=ALU 1=MEM 2=PC+4
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_addr  out  XLEN  word-aligned address (bits[1:0]=0)
dmem_req_we  out  1  store
dmem_req_wdata  out  XLEN  lane-replicated store data
dmem_req_wstrb  out  4  byte strobes
dmem_resp_valid  in  1  response valid (single-cycle pulse)
dmem_resp_data  in  XLEN  read word
mem_stall  out  1  hold execute and upstream stages
wb_valid  out  1  writeback bundle valid
wb_pc  out  XLEN  PC of retiring instruction
wb_addr  out  5  destination register
wb_wen  out  1  register write
wb_data  out  XLEN  writeback data
wb_exc  out  2  0=none 1=misaligned 2=bus timeout

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; every output 0; in-flight access abandoned; late responses after reset ignored.
- FSM states: IDLE, WAIT_REQ, WAIT_RESP.
- Input sampled only in IDLE with mem_stall low. Non-memory instruction (ex_mem_val=0 or ex_valid=0): registered to wb_* next cycle; 1-cycle latency; no stall.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0, or illegal typ -> no request, wb_valid=1, wb_wen=0, wb_exc=1, next cycle.
- Memory instruction, aligned: dmem_req_valid asserted combinationally in the accept cycle; mem_stall=1 in that cycle. Request fields are held stable until ready. If dmem_req_ready is high the same cycle, go to WAIT_RESP; otherwise go to WAIT_REQ.
- WAIT_REQ: hold request and mem_stall=1; on dmem_req_ready go to WAIT_RESP.
- WAIT_RESP: mem_stall=1; wb_valid=0. On dmem_resp_valid: register wb_* (wb_valid=1 for one cycle), return to IDLE; mem_stall deasserts in the response cycle, so execute advances on the same edge the result registers. Minimum load/store latency is 2 cycles.
- Stores also wait for a response (acknowledge); for stores wb_wen=0.
- Response in same cycle as request acceptance is illegal and ignored.
- Timeout: 8-bit counter cleared on entry to WAIT_RESP. At RESP_TIMEOUT cycles without a response: wb_valid=1, wb_wen=0, wb_exc=2, go to IDLE. A later stray response is ignored.
- Store formatting: B -> wdata={4{rs2[7:0]}}, wstrb=1<<addr[1:0]; H -> {2{rs2[15:0]}}, wstrb=addr[1]?1100:0011; W -> rs2, 1111. Loads: we=0, wstrb=0000, wdata=0.
- Load extraction: byte lane = addr[1:0], half lane = addr[1]. B/H sign-extend, BU/HU zero-extend, W passthrough.
- wb_data mux: ALU -> alu_out; MEM -> extracted load data; PC+4 -> pc+4 (mod 2^32, wraps).
- wb_addr=0 forces wb_wen=0.
- wb_valid low -> wb_wen low. Bubbles produce wb_valid=0.

Test Plan:
- ALU op: alu_out=0x1234, wb_addr=5, rf_wen=1, mem_val=0 -> next cycle wb_valid=1, wb_data=0x1234, wb_wen=1, mem_stall never high.
- LB at addr 0x103, ready=1, resp after 1 cycle with data 0x80FFFFFF -> req_addr=0x100, wb_data=0xFFFFFF80; LBU same -> 0x00000080; mem_stall high exactly 2 cycles.
- SH rs2=0xDEADBEEF at 0x202, ready low 3 cycles -> request held constant, wdata=0xBEEFBEEF, wstrb=1100, we=1; after ack wb_wen=0.
- LW at 0x101 -> no dmem_req_valid, wb_exc=1, wb_wen=0, 1-cycle latency.
- No response for 255 cycles -> wb_exc=2, IDLE; stray resp on next cycle ignored; rst_n pulsed low mid-WAIT_RESP -> all outputs 0 immediately.
- JAL wb_sel=PC+4, pc=0xFFFFFFFC -> wb_data=0x00000000; rf_wen=1 with wb_addr=0 -> wb_wen=0.
